// File: rtl/mor1kx_irq_arbiter.sv
// mor1kx_irq_arbiter: fixed-priority interrupt arbiter between the PIC
// status word and the control stage. It issues exactly one registered
// interrupt request per service and then waits for the handler to return.
//
// Optional feature macro: MOR1KX_IRQ_ARB_LATENCY_CNT_EN
//   When defined, it adds irq_latency_o. This output gives the number of cycles
//   the last request was held before it was accepted or withdrawn. The count
//   saturates at 16'hFFFF.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request outstanding; arbitrate eligible lines each cycle
// REQ     | irq_o high, line frozen; wait for accept or withdraw
// SERVICE | handler running; wait for l.rfe or software IEE re-enable

module mor1kx_irq_arbiter #(
   parameter string OPTION_IRQ_PRIORITY  = "LOW_FIRST",
   parameter int    OPTION_PIC_NMI_WIDTH = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] spr_picsr_i,
   input  logic        spr_sr_iee_i,
   input  logic        du_stall_i,
   input  logic        exception_taken_i,
   input  logic        rfe_i,
   output logic        irq_o,
   output logic [4:0]  irq_line_o,
   output logic        irq_nmi_o,
`ifdef MOR1KX_IRQ_ARB_LATENCY_CNT_EN
   output logic [15:0] irq_latency_o,
`endif
   output logic        irq_pending_o
);

   // An unsupported option stops elaboration instead of building the wrong priority order.
   if (OPTION_IRQ_PRIORITY != "LOW_FIRST" && OPTION_IRQ_PRIORITY != "HIGH_FIRST") begin : g_bad_prio
      $fatal(1, "mor1kx_irq_arbiter: OPTION_IRQ_PRIORITY must be LOW_FIRST or HIGH_FIRST");
   end
   if (OPTION_PIC_NMI_WIDTH < 0 || OPTION_PIC_NMI_WIDTH > 31) begin : g_bad_nmi
      $fatal(1, "mor1kx_irq_arbiter: OPTION_PIC_NMI_WIDTH must be 0..31");
   end

   localparam bit          PRIO_HIGH = (OPTION_IRQ_PRIORITY == "HIGH_FIRST");
   // The low NMI lines are set in this mask, and they ignore IEE.
   localparam logic [31:0] NMI_MASK  = (32'd1 << OPTION_PIC_NMI_WIDTH) - 32'd1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_irq;
   logic        w_irq_nxt;
   logic [4:0]  r_irq_line;
   logic [4:0]  w_line_nxt;
   logic        r_irq_nmi;
   logic        w_nmi_nxt;
   logic        r_iee_seen_low;
   logic        w_seen_nxt;
   logic        r_pending;

   logic [31:0] w_eligible;
   logic        w_any;
   logic [4:0]  w_sel;
   logic        w_sel_nmi;
   logic        w_line_ok;

   assign w_eligible = spr_picsr_i & ({32{spr_sr_iee_i}} | NMI_MASK);
   assign w_any      = |w_eligible;
   assign w_sel_nmi  = NMI_MASK[w_sel];
   // The latched line stays requestable only while it is still pending and still enabled.
   assign w_line_ok  = spr_picsr_i[r_irq_line] & (spr_sr_iee_i | r_irq_nmi);

   // Fixed-priority encode. The last match in the loop wins, so the scan runs toward the preferred end.
   always_comb begin
      w_sel = 5'd0;
      if (PRIO_HIGH) begin
         for (int i = 0; i < 32; i++) begin
            if (w_eligible[i]) w_sel = 5'(i);
         end
      end else begin
         for (int i = 31; i >= 0; i--) begin
            if (w_eligible[i]) w_sel = 5'(i);
         end
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_irq_nxt   = 1'b0;
      w_line_nxt  = r_irq_line;
      w_nmi_nxt   = r_irq_nmi;
      w_seen_nxt  = r_iee_seen_low;
      case (r_state)
         IDLE: begin
            if (w_any && !du_stall_i) begin
               w_state_nxt = REQ;
               w_irq_nxt   = 1'b1;
               w_line_nxt  = w_sel;
               w_nmi_nxt   = w_sel_nmi;
            end
         end
         REQ: begin
            w_irq_nxt = 1'b1;
            if (exception_taken_i) begin
               w_state_nxt = SERVICE;
               w_irq_nxt   = 1'b0;
               w_seen_nxt  = 1'b0;
            end else if (!w_line_ok) begin
               w_state_nxt = IDLE;
               w_irq_nxt   = 1'b0;
            end
         end
         SERVICE: begin
            w_seen_nxt = r_iee_seen_low | ~spr_sr_iee_i;
            // IEE can still read high for a cycle after the exception is accepted. Only a rising IEE after a low counts as a re-enable.
            if (rfe_i || (spr_sr_iee_i && r_iee_seen_low)) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_irq          <= 1'b0;
         r_irq_line     <= 5'd0;
         r_irq_nmi      <= 1'b0;
         r_iee_seen_low <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_irq          <= w_irq_nxt;
         r_irq_line     <= w_line_nxt;
         r_irq_nmi      <= w_nmi_nxt;
         r_iee_seen_low <= w_seen_nxt;
      end
   end

   // Pending summary tracks the PIC every cycle regardless of arbitration state.
   always_ff @(posedge clk) begin
      if (rst) r_pending <= 1'b0;
      else     r_pending <= |spr_picsr_i;
   end

`ifdef MOR1KX_IRQ_ARB_LATENCY_CNT_EN
   logic [15:0] r_latency;

   // Request hold-time counter: cleared on entry to REQ, counts while in REQ, frozen elsewhere.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_latency <= 16'd0;
      end else if (r_state == IDLE && w_state_nxt == REQ) begin
         r_latency <= 16'd0;
      end else if (r_state == REQ && r_latency != 16'hFFFF) begin
         r_latency <= r_latency + 16'd1;
      end
   end

   assign irq_latency_o = r_latency;
`endif

   assign irq_o         = r_irq;
   assign irq_line_o    = r_irq_line;
   assign irq_nmi_o     = r_irq_nmi;
   assign irq_pending_o = r_pending;

endmodule
